// File: rtl/mem_wait_responder.sv
// mem_wait_responder: memory bus responder with wait states, ready/error handshake and word storage
module mem_wait_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Mem_ready,
  output logic        Mem_error,
  output logic        Busy
);
  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [IW-1:0] idx;
  logic [31:0] wdata, off;
  logic we, err, req;
  logic [31:0] mem [DEPTH_WORDS];
  assign req = MemRead | MemWrite;
  assign off = Address - BASE_ADDR;
  assign Busy = state != IDLE;
  assign Mem_ready = state == RESP;
  assign Mem_error = Mem_ready & err;
  assign Read_data = (Mem_ready & ~err & ~we) ? mem[idx] : 32'd0;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
      WAIT: state_n = cnt == 4'd1 ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      wdata <= '0;
      we <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        cnt <= 4'(WAIT_CYCLES);
        idx <= off[IW+1:2];
        wdata <= Write_data;
        we <= MemWrite;
        err <= (|Address[1:0]) | (off >= SPAN) | (MemRead & MemWrite);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP && we && !err) mem[idx] <= wdata;
    end
  end
endmodule
